fetchinstrgen_udiv_seq: RTL

Sequential unsigned restoring divider, one quotient bit per cycle. It inverts the fetch-address multiplier: it recovers a tile index and offset from a linear fetch address, computing quotient = dividend / divisor and remainder = dividend mod divisor. It sits in the FetchInstrGen datapath between the instruction-field decoder and the address-range checker. The upstream side uses a valid/ready handshake and the downstream side uses a valid/ready handshake.

---
 rtl/fetchinstrgen_udiv_seq_pkg.sv | 16 +
 rtl/fetchinstrgen_udiv_seq_if.sv | 35 +++
 rtl/fetchinstrgen_udiv_step.sv | 31 +++
 rtl/fetchinstrgen_udiv_seq.sv | 107 ++++++++++
 4 files changed

// File: rtl/fetchinstrgen_udiv_seq_pkg.sv
// Shared definitions for the FetchInstrGen sequential unsigned divider.
// Provides default operand widths, the controller state type and the
// iteration counter width.
package fetchinstrgen_div_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 20;
  localparam int unsigned DEF_DIVISOR_W  = 16;
  localparam int unsigned CNT_W          = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fetchinstrgen_udiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// Signals:
//   in_valid/in_ready      operand handshake, in_dividend/in_divisor payload
//   out_valid/out_ready    result handshake, out_quot/out_rem/out_dbz payload
// Modports:
//   master  producer of operands and consumer of results
//   slave   the divider itself
interface fetchinstrgen_udiv_seq_if
  import fetchinstrgen_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] in_dividend;
  logic [DIVISOR_W-1:0]  in_divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] out_quot;
  logic [DIVISOR_W-1:0]  out_rem;
  logic                  out_dbz;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz
  );

endinterface

// File: rtl/fetchinstrgen_udiv_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   partial remainder entering the step (always < divisor)
//   bit_in   next dividend bit shifted into the remainder
//   divisor  divisor operand
//   rem_out  partial remainder after the conditional subtract
//   q_bit    quotient bit produced by this step
module fetchinstrgen_udiv_step #(
  parameter int unsigned DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  // The shifted remainder is DIVISOR_W+1 bits: {carry, low}. A set carry
  // means it already exceeds any divisor; the subtract result always fits
  // in DIVISOR_W bits, so modular subtraction on the low part is exact.
  logic                 carry;
  logic [DIVISOR_W-1:0] low;

  always_comb begin
    carry   = rem_in[DIVISOR_W-1];
    low     = {rem_in[DIVISOR_W-2:0], bit_in};
    q_bit   = carry | (low >= divisor);
    rem_out = q_bit ? (low - divisor) : low;
  end

endmodule

// File: rtl/fetchinstrgen_udiv_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Recovers tile index (quotient) and offset (remainder) from a linear
// fetch address.
// Ports:
//   ap_clk    rising-edge clock
//   ap_rst_n  asynchronous active-low reset
//   bus       slave side of the operand/result handshake bundle
module fetchinstrgen_udiv_seq
  import fetchinstrgen_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  fetchinstrgen_udiv_seq_if.slave  bus
);

  localparam int unsigned        CW       = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DIVIDEND_W - 1);

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  rem;
  logic [CW-1:0]         cnt;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;

  // Dividend MSB feeds the step; the freed LSB collects quotient bits.
  fetchinstrgen_udiv_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[DIVIDEND_W-1]),
    .divisor (dsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = (bus.in_divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        if (bus.out_valid && bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs. A divide-by-zero enters DONE
  // straight from IDLE, and out_valid follows one cycle later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_quot  <= '0;
      bus.out_rem   <= '0;
      bus.out_dbz   <= 1'b0;
    end else begin
      bus.in_ready  <= (state_next == IDLE);
      bus.out_valid <= (state_next == DONE) && (state != IDLE);
      if (accept) begin
        dvd <= bus.in_dividend;
        dsr <= bus.in_divisor;
        rem <= '0;
        cnt <= CNT_LAST;
        if (bus.in_divisor == '0) begin
          bus.out_quot <= '1;
          bus.out_rem  <= bus.in_dividend[DIVISOR_W-1:0];
          bus.out_dbz  <= 1'b1;
        end
      end else if (state == CALC) begin
        dvd <= {dvd[DIVIDEND_W-2:0], step_q};
        rem <= step_rem;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          bus.out_quot <= {dvd[DIVIDEND_W-2:0], step_q};
          bus.out_rem  <= step_rem;
          bus.out_dbz  <= 1'b0;
        end
      end
    end
  end

endmodule
